// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: shares the formatter between the slave channels, granting by
// programmable priority (0 = highest) with round-robin among equal priorities.
module mcdf_arbiter #(
    parameter int CH_NUM     = 3,
    parameter int PRIO_WIDTH = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [CH_NUM*PRIO_WIDTH-1:0] slv_prios,
    input  logic [CH_NUM-1:0]            slv_reqs,
    input  logic [CH_NUM-1:0]            slv_vals,
    input  logic [CH_NUM*DATA_WIDTH-1:0] slv_datas,
    input  logic                         f2a_id_req,
    input  logic                         f2a_done,
    output logic [CH_NUM-1:0]            a2s_acks,
    output logic [1:0]                   a2f_id,
    output logic                         a2f_val,
    output logic [DATA_WIDTH-1:0]        a2f_data,
    output logic                         dbg_state
);

    // Handshake: a grant is a one-cycle a2s_acks pulse plus a registered
    // a2f_id; in BUSY the formatter takes a beat on every edge where a2f_val=1,
    // and a one-cycle f2a_done closes the packet.

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          a2f_id_q, a2f_id_d;
    logic [1:0]          last_id_q, last_id_d;
    logic [CH_NUM-1:0]   acks_q, acks_d;

    logic [PRIO_WIDTH-1:0] prio_a [CH_NUM];
    logic [DATA_WIDTH-1:0] data_a [CH_NUM];

    logic                  found;
    logic [1:0]            win_id;
    logic [PRIO_WIDTH-1:0] win_prio;
    logic [1:0]            idx_b;
    int                    idx;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            prio_a[i] = slv_prios[i*PRIO_WIDTH +: PRIO_WIDTH];
            data_a[i] = slv_datas[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan in round-robin order from last_id+1; strict '<' keeps the first
    // tied requester met in that order.
    always_comb begin
        found    = 1'b0;
        win_id   = '0;
        win_prio = '1;
        idx      = 0;
        idx_b    = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = int'(last_id_q) + 1 + k;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
            idx_b = 2'(idx);
            if (slv_reqs[idx_b] && (!found || prio_a[idx_b] < win_prio)) begin
                found    = 1'b1;
                win_id   = idx_b;
                win_prio = prio_a[idx_b];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a2f_id_d  = a2f_id_q;
        last_id_d = last_id_q;
        acks_d    = '0;
        case (state_q)
            IDLE: begin
                if (f2a_id_req && found) begin
                    state_d        = BUSY;
                    a2f_id_d       = win_id;
                    last_id_d      = win_id;
                    acks_d[win_id] = 1'b1;
                end
            end
            BUSY: begin
                if (f2a_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            a2f_id_q  <= '0;
            last_id_q <= 2'(CH_NUM - 1);
            acks_q    <= '0;
        end else begin
            state_q   <= state_d;
            a2f_id_q  <= a2f_id_d;
            last_id_q <= last_id_d;
            acks_q    <= acks_d;
        end
    end

    assign a2s_acks  = acks_q;
    assign a2f_id    = a2f_id_q;
    assign a2f_val   = (state_q == BUSY) && slv_vals[a2f_id_q];
    assign a2f_data  = a2f_val ? data_a[a2f_id_q] : '0;
    assign dbg_state = (state_q == BUSY);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed self-checking bench for mcdf_arbiter: grant order, priority,
// data muxing, idle requests, done/req overlap and mid-packet reset.
module tb_mcdf_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  slv_prios;
    logic [2:0]  slv_reqs;
    logic [2:0]  slv_vals;
    logic [95:0] slv_datas;
    logic        f2a_id_req;
    logic        f2a_done;
    logic [2:0]  a2s_acks;
    logic [1:0]  a2f_id;
    logic        a2f_val;
    logic [31:0] a2f_data;
    logic        dbg_state;

    int checks   = 0;
    int failures = 0;

    mcdf_arbiter dut (
        .clk(clk), .rstn(rstn), .slv_prios(slv_prios), .slv_reqs(slv_reqs),
        .slv_vals(slv_vals), .slv_datas(slv_datas), .f2a_id_req(f2a_id_req),
        .f2a_done(f2a_done), .a2s_acks(a2s_acks), .a2f_id(a2f_id),
        .a2f_val(a2f_val), .a2f_data(a2f_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // drive point: just after the active edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rstn = 1'b1;
        cyc();
        cyc();
        rstn = 1'b0;
    endtask

    // returns at the negedge where an ack is seen, or times out
    task automatic wait_ack(output logic [2:0] ack, output logic [1:0] id, output bit to);
        bit seen = 1'b0;
        ack = '0; id = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (a2s_acks != 3'b000) begin
                seen = 1'b1;
                ack  = a2s_acks;
                id   = a2f_id;
            end
        end
        to = !seen;
    endtask

    task automatic do_done();
        cyc();
        f2a_done = 1'b1;
        cyc();
        f2a_done = 1'b0;
    endtask

    task automatic test_reset();
        slv_prios = '0; slv_reqs = '0; slv_vals = '0; slv_datas = '0;
        f2a_id_req = 1'b0; f2a_done = 1'b0; rstn = 1'b0;
        do_reset();
        @(negedge clk);
        checks += 5;
        if (a2s_acks !== 3'b000) begin failures++; $display("FAIL reset_acks got=%b exp=000", a2s_acks); end
        if (a2f_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", a2f_id); end
        if (a2f_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%b exp=0", a2f_val); end
        if (a2f_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", a2f_data); end
        if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [2:0] ack;
        logic [1:0] id;
        bit         to;
        do_reset();
        slv_prios = '0; slv_reqs = 3'b111; slv_vals = 3'b111;
        slv_datas = {32'h2222_0000, 32'h1111_0000, 32'h0000_0000};
        f2a_id_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_ack(ack, id, to);
            checks++;
            if (to) begin
                failures++; $display("FAIL rr_timeout grant=%0d", g);
            end else begin
                checks += 2;
                if (ack !== (3'b001 << exp_order[g])) begin
                    failures++; $display("FAIL rr_ack grant=%0d got=%b exp_ch=%0d", g, ack, exp_order[g]);
                end
                if (id !== exp_order[g]) begin
                    failures++; $display("FAIL rr_id grant=%0d got=%0d exp=%0d", g, id, exp_order[g]);
                end
                cyc();
                @(negedge clk);
                if (a2s_acks !== 3'b000) begin
                    failures++; $display("FAIL rr_ack_width grant=%0d got=%b exp=000", g, a2s_acks);
                end
                cyc();
                do_done();
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0] ack;
        logic [1:0] id;
        bit         to;
        do_reset();
        slv_prios = {2'd1, 2'd0, 2'd2};
        slv_reqs = 3'b111; f2a_id_req = 1'b1;
        for (int g = 0; g < 2; g++) begin
            wait_ack(ack, id, to);
            checks++;
            if (to) begin
                failures++; $display("FAIL prio_timeout grant=%0d", g);
            end else if (ack !== 3'b010 || id !== 2'd1) begin
                failures++; $display("FAIL prio_grant grant=%0d got_ack=%b got_id=%0d exp_ack=010 exp_id=1", g, ack, id);
            end
            do_done();
        end
        f2a_id_req = 1'b0;
    endtask

    task automatic test_data_mux();
        logic [2:0]  ack;
        logic [1:0]  id;
        bit          to;
        logic [5:0]  pat = 6'b101101;
        logic [31:0] word = 32'hA5A5_0001;
        logic [31:0] exp_d;
        do_reset();
        slv_prios = '0; slv_reqs = 3'b100; slv_vals = 3'b000; f2a_id_req = 1'b1;
        wait_ack(ack, id, to);
        checks++;
        if (to || id !== 2'd2) begin
            failures++; $display("FAIL data_grant got_id=%0d timeout=%0d exp_id=2", id, to);
        end
        f2a_id_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            slv_reqs  = 3'b011;
            slv_vals  = {pat[k], 1'b0, 1'b1};
            slv_datas = {word, 32'h0BAD_0BAD, 32'hDEAD_BEEF};
            exp_d     = pat[k] ? word : 32'h0;
            @(negedge clk);
            checks += 2;
            if (a2f_val !== pat[k]) begin
                failures++; $display("FAIL data_val beat=%0d got=%b exp=%b", k, a2f_val, pat[k]);
            end
            if (a2f_data !== exp_d) begin
                failures++; $display("FAIL data_word beat=%0d got=%h exp=%h", k, a2f_data, exp_d);
            end
            if (pat[k]) word = word + 32'd1;
        end
        do_done();
        slv_vals = 3'b000;
    endtask

    task automatic test_no_request();
        logic [2:0] ack;
        logic [1:0] id;
        bit         to;
        slv_reqs = 3'b000; f2a_id_req = 1'b1; slv_prios = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            @(negedge clk);
            checks++;
            if (a2s_acks !== 3'b000 || dbg_state !== 1'b0) begin
                failures++; $display("FAIL noreq_idle cyc=%0d got_ack=%b got_busy=%b exp=000/0", k, a2s_acks, dbg_state);
            end
        end
        cyc();
        slv_reqs = 3'b010;
        wait_ack(ack, id, to);
        checks++;
        if (to || ack !== 3'b010 || id !== 2'd1) begin
            failures++; $display("FAIL noreq_first got_ack=%b got_id=%0d timeout=%0d exp=010/1", ack, id, to);
        end
    endtask

    // enters in BUSY on ch1 with last_id=1
    task automatic test_done_and_req();
        cyc();
        slv_reqs = 3'b111; slv_vals = 3'b111; f2a_id_req = 1'b1; f2a_done = 1'b1;
        cyc();
        f2a_done = 1'b0;
        @(negedge clk);
        checks++;
        if (a2f_val !== 1'b0 || a2s_acks !== 3'b000 || dbg_state !== 1'b0) begin
            failures++; $display("FAIL overlap_gap got_val=%b got_ack=%b got_busy=%b exp=0/000/0", a2f_val, a2s_acks, dbg_state);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (a2s_acks !== 3'b100 || a2f_id !== 2'd2) begin
            failures++; $display("FAIL overlap_regrant got_ack=%b got_id=%0d exp=100/2", a2s_acks, a2f_id);
        end
        f2a_id_req = 1'b0;
        do_done();
    endtask

    task automatic test_reset_mid_packet();
        logic [2:0] ack;
        logic [1:0] id;
        bit         to;
        slv_reqs = 3'b010; slv_vals = 3'b111; f2a_id_req = 1'b1;
        slv_datas = {32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        wait_ack(ack, id, to);
        checks++;
        if (to || id !== 2'd1) begin
            failures++; $display("FAIL rst_setup got_id=%0d timeout=%0d exp=1", id, to);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (a2f_data !== 32'h4444_4444) begin
            failures++; $display("FAIL rst_busy_data got=%h exp=44444444", a2f_data);
        end
        cyc();
        rstn = 1'b1; slv_reqs = 3'b111;
        cyc();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (a2s_acks !== 3'b000 || a2f_id !== 2'd0 || a2f_val !== 1'b0 ||
            a2f_data !== 32'h0 || dbg_state !== 1'b0) begin
            failures++;
            $display("FAIL rst_outputs got_ack=%b id=%0d val=%b data=%h busy=%b exp=all_zero",
                     a2s_acks, a2f_id, a2f_val, a2f_data, dbg_state);
        end
        wait_ack(ack, id, to);
        checks++;
        if (to || ack !== 3'b001 || id !== 2'd0) begin
            failures++; $display("FAIL rst_first_grant got_ack=%b got_id=%0d timeout=%0d exp=001/0", ack, id, to);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_data_mux();
        test_no_request();
        test_done_and_req();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
